fsm_ring_seq: RTL

- Parametrised Moore state machine that cycles through NUM_STATES states arranged in a ring.
- Each state drives an encoded output value; this generalises the two-state colour FSM to N states.
- Adds advance, retreat and jump commands, a minimum-dwell interlock, an auto-advance timeout and a transition pulse.
- Used as a reusable mode/phase sequencer inside generated controllers.

---
 rtl/fsm_ring_seq_if.sv | 35 +++
 rtl/fsm_ring_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fsm_ring_seq_if.sv
// Command/status bundle for the ring sequencer.
// FSM_RING_RANGE_CHECK_EN adds the sticky err flag.
interface fsm_ring_seq_if #(
  parameter int STATE_W   = 2,
  parameter int OUT_WIDTH = 2
);
  logic [1:0]           in;
  logic [STATE_W-1:0]   jump_target;
  logic [OUT_WIDTH-1:0] out;
  logic [STATE_W-1:0]   state;
  logic                 busy;
  logic                 changed;
  logic                 timeout;
`ifdef FSM_RING_RANGE_CHECK_EN
  logic                 err;

  modport master (
    output in, jump_target,
    input  out, state, busy, changed, timeout, err
  );
  modport slave (
    input  in, jump_target,
    output out, state, busy, changed, timeout, err
  );
`else
  modport master (
    output in, jump_target,
    input  out, state, busy, changed, timeout
  );
  modport slave (
    input  in, jump_target,
    output out, state, busy, changed, timeout
  );
`endif
endinterface

// File: rtl/fsm_ring_seq.sv
// N-state ring sequencer with dwell interlock and auto-advance.
// FSM_RING_RANGE_CHECK_EN: reject out-of-range jumps and flag err.
module fsm_ring_seq #(
  parameter int NUM_STATES  = 4,
  parameter int OUT_WIDTH   = 2,
  parameter int RESET_STATE = 1,
  parameter int MIN_DWELL   = 2,
  parameter int TIMEOUT     = 8
) (
  input logic           clk,
  input logic           rst,
  fsm_ring_seq_if.slave bus
);
  localparam int STATE_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int DW  = (MIN_DWELL > TIMEOUT) ? MIN_DWELL : TIMEOUT;
  localparam int CW  = (DW > 0) ? $clog2(DW + 1) : 1;
  localparam int OW1 = ((STATE_W > OUT_WIDTH) ? STATE_W : OUT_WIDTH) + 1;

  typedef logic [STATE_W-1:0] st_t;
  typedef logic [STATE_W:0]   stw_t;
  typedef logic [CW-1:0]      cnt_t;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'h0,
    CMD_ADV  = 2'h1,
    CMD_RET  = 2'h2,
    CMD_JMP  = 2'h3
  } cmd_e;

  localparam st_t  LAST   = st_t'(NUM_STATES - 1);
  localparam st_t  RST_ST = st_t'(RESET_STATE);
  localparam stw_t N_W    = stw_t'(NUM_STATES);
  localparam cnt_t MIN_C  = cnt_t'(MIN_DWELL);
  localparam cnt_t DW_C   = cnt_t'(DW);
  localparam cnt_t TO_C   = cnt_t'(TIMEOUT - 1);

  if (NUM_STATES < 2) begin : g_chk_n
    $error("NUM_STATES must be >= 2");
  end
  if (RESET_STATE >= NUM_STATES) begin : g_chk_rs
    $error("RESET_STATE out of range");
  end
  if (!(TIMEOUT == 0 || TIMEOUT > MIN_DWELL)) begin : g_chk_to
    $error("TIMEOUT must be 0 or greater than MIN_DWELL");
  end

  st_t  state_q, state_d;
  cnt_t dwell_q, dwell_d;
  logic changed_q, changed_d;
  logic timeout_q, timeout_d;
  logic err_q, err_d;

  cmd_e cmd;
  logic busy, accept, tmo, st_bad, jt_oor;
  st_t  adv, ret;

  always_comb begin
    cmd    = cmd_e'(bus.in);
    busy   = dwell_q < MIN_C;
    accept = !busy && cmd != CMD_HOLD;
    tmo    = (TIMEOUT > 0) && cmd == CMD_HOLD
             && !busy && dwell_q == TO_C;
    st_bad = {1'b0, state_q} >= N_W;
    jt_oor = {1'b0, bus.jump_target} >= N_W;
    adv    = (state_q == LAST) ? '0 : state_q + 1'b1;
    ret    = (state_q == '0) ? LAST : state_q - 1'b1;

    state_d   = state_q;
    err_d     = err_q;
    timeout_d = 1'b0;

    unique case (1'b1)
      st_bad:
        state_d = RST_ST;
      !st_bad && accept && cmd == CMD_ADV:
        state_d = adv;
      !st_bad && accept && cmd == CMD_RET:
        state_d = ret;
      !st_bad && accept && cmd == CMD_JMP: begin
`ifdef FSM_RING_RANGE_CHECK_EN
        if (jt_oor) err_d = 1'b1;
        else        state_d = bus.jump_target;
`else
        state_d = jt_oor ? LAST : bus.jump_target;
`endif
      end
      !st_bad && tmo: begin
        state_d   = adv;
        timeout_d = 1'b1;
      end
      default: ;
    endcase

    changed_d = state_d != state_q;
    if (changed_d)            dwell_d = '0;
    else if (dwell_q == DW_C) dwell_d = dwell_q;
    else                      dwell_d = dwell_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_ST;
      dwell_q   <= MIN_C;
      changed_q <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      changed_q <= changed_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.out     = OUT_WIDTH'(OW1'(state_q) + OW1'(1));
  assign bus.busy    = busy;
  assign bus.changed = changed_q;
  assign bus.timeout = timeout_q;
`ifdef FSM_RING_RANGE_CHECK_EN
  assign bus.err     = err_q;
`else
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif
endmodule
